// File: rtl/riscv_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// riscv_ctrl_pkg
// Shared types and constants for the core run controller:
//   run_state_e  - controller FSM states (encoding is visible on the state port)
//   halt_cause_e - reason the controller last stopped the core
//   NOP_INSTR    - RV32I canonical NOP (addi x0,x0,0), used as end-of-program
// -----------------------------------------------------------------------------
package riscv_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RSTC = 3'd1,
    ST_RUN  = 3'd2,
    ST_HALT = 3'd3,
    ST_STEP = 3'd4,
    ST_DONE = 3'd5
  } run_state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE = 2'd0,
    CAUSE_HALT = 2'd1,
    CAUSE_BP   = 2'd2,
    CAUSE_STEP = 2'd3
  } halt_cause_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage : riscv_ctrl_pkg

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Up-counter with synchronous clear and saturation at all-ones.
//   clk_i  - clock (rising edge)
//   rst_i  - asynchronous active-high reset, forces count to zero
//   clr_i  - synchronous clear, has priority over enable
//   en_i   - count enable
//   cnt_o  - current count value
// -----------------------------------------------------------------------------
module sat_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule : sat_counter

// File: rtl/core_run_ctrl.sv
// -----------------------------------------------------------------------------
// core_run_ctrl
// Run controller for a small RISC-V core: holds the core in reset after start,
// lets it run, stops it on halt request / breakpoint / watchdog, supports
// single-stepping from HALT and detects the end-of-program marker.
//
// Parameters
//   RST_CYCLES - cycles core_rst is held after a start from IDLE/DONE
//   MAX_CYCLES - watchdog limit in retired instructions
//   MIN_CYCLES - retired count below which the end marker is ignored
//   END_INSTR  - end-of-program marker instruction
//
// Ports
//   clk       - clock, rising edge
//   reset     - asynchronous active-high reset
//   start     - pulse: restart from IDLE/DONE, resume from HALT
//   halt_req  - level: stop RUN before the current instruction retires
//   step_req  - pulse: retire exactly one instruction from HALT
//   bp_en     - breakpoint enable
//   bp_addr   - breakpoint PC
//   pc        - core PC
//   instr     - instruction currently fetched by the core
//   core_rst  - core held in reset (IDLE, RSTC)
//   core_en   - core retires the current instruction at the next edge
//   state     - FSM encoding
//   cause     - last stop reason (0 none, 1 halt_req, 2 breakpoint, 3 step)
//   cycle_cnt - retired instructions since last start from IDLE/DONE
//   done      - end of program reached
//   timeout   - watchdog expired
// -----------------------------------------------------------------------------
module core_run_ctrl
  import riscv_ctrl_pkg::*;
#(
  parameter int unsigned RST_CYCLES = 3,
  parameter int unsigned MAX_CYCLES = 1000,
  parameter int unsigned MIN_CYCLES = 5,
  parameter logic [31:0] END_INSTR  = NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        halt_req,
  input  logic        step_req,
  input  logic        bp_en,
  input  logic [31:0] bp_addr,
  input  logic [31:0] pc,
  input  logic [31:0] instr,
  output logic        core_rst,
  output logic        core_en,
  output logic [2:0]  state,
  output logic [1:0]  cause,
  output logic [31:0] cycle_cnt,
  output logic        done,
  output logic        timeout
);

  run_state_e  state_q,   state_d;
  halt_cause_e cause_q,   cause_d;
  logic        done_q,    done_d;
  logic        timeout_q, timeout_d;
  logic        skip_q,    skip_d;
  logic [31:0] rst_cnt_q, rst_cnt_d;

  logic        cnt_clr;
  logic [31:0] cnt;

  logic        stop_halt;
  logic        stop_bp;
  logic        stop_wd;
  logic        stop;
  logic        end_hit;

  // Stop conditions are only meaningful in RUN; the FSM qualifies them there.
  always_comb begin
    stop_halt = halt_req;
    stop_bp   = bp_en && (pc == bp_addr) && !skip_q;
    // >= rather than == so a count pushed past the limit by stepping still
    // trips the watchdog on resume.
    stop_wd   = (cnt >= 32'(MAX_CYCLES));
    stop      = stop_halt || stop_bp || stop_wd;
    end_hit   = (instr == END_INSTR) && (cnt >= 32'(MIN_CYCLES));
  end

  always_comb begin
    state_d   = state_q;
    cause_d   = cause_q;
    done_d    = done_q;
    timeout_d = timeout_q;
    skip_d    = skip_q;
    rst_cnt_d = rst_cnt_q;
    cnt_clr   = 1'b0;
    core_rst  = 1'b0;
    core_en   = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        core_rst = (state_q == ST_IDLE);
        if (start) begin
          state_d   = ST_RSTC;
          rst_cnt_d = '0;
          cnt_clr   = 1'b1;
          done_d    = 1'b0;
          timeout_d = 1'b0;
          cause_d   = CAUSE_NONE;
          skip_d    = 1'b0;
        end
      end

      ST_RSTC: begin
        core_rst = 1'b1;
        if (rst_cnt_q >= 32'(RST_CYCLES - 1)) begin
          state_d = ST_RUN;
        end else begin
          rst_cnt_d = rst_cnt_q + 32'd1;
        end
      end

      ST_RUN: begin
        core_en = !stop;
        if (stop_halt) begin
          state_d = ST_HALT;
          cause_d = CAUSE_HALT;
        end else if (stop_bp) begin
          state_d = ST_HALT;
          cause_d = CAUSE_BP;
        end else if (stop_wd) begin
          state_d   = ST_DONE;
          timeout_d = 1'b1;
        end else begin
          // An instruction retires this cycle, so the resume-at-breakpoint
          // exemption has been used up.
          skip_d = 1'b0;
          if (end_hit) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end
      end

      ST_HALT: begin
        if (start) begin
          state_d = ST_RUN;
          skip_d  = 1'b1;
        end else if (step_req) begin
          state_d = ST_STEP;
        end
      end

      ST_STEP: begin
        core_en = 1'b1;
        state_d = ST_HALT;
        cause_d = CAUSE_STEP;
      end

      default: begin
        core_rst = 1'b1;
        state_d  = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cause_q   <= CAUSE_NONE;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      skip_q    <= 1'b0;
      rst_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      cause_q   <= cause_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
      skip_q    <= skip_d;
      rst_cnt_q <= rst_cnt_d;
    end
  end

  sat_counter #(
    .WIDTH(32)
  ) u_cycle_cnt (
    .clk_i (clk),
    .rst_i (reset),
    .clr_i (cnt_clr),
    .en_i  (core_en),
    .cnt_o (cnt)
  );

  assign state     = state_q;
  assign cause     = cause_q;
  assign cycle_cnt = cnt;
  assign done      = done_q;
  assign timeout   = timeout_q;

endmodule : core_run_ctrl

// File: tb/tb_core_run_ctrl.sv
module tb_core_run_ctrl;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] ADD = 32'h0000_0033;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        halt_req = 1'b0;
  logic        step_req = 1'b0;
  logic        bp_en = 1'b0;
  logic [31:0] bp_addr = '0;
  logic [31:0] pc = '0;
  logic [31:0] instr;
  logic        core_rst;
  logic        core_en;
  logic [2:0]  state;
  logic [1:0]  cause;
  logic [31:0] cycle_cnt;
  logic        done;
  logic        timeout;

  logic [31:0] prog [64];

  typedef struct {
    string       name;
    logic [2:0]  st;
    logic [1:0]  cause;
    logic [31:0] cnt;
    logic        done;
    logic        to;
    logic [31:0] pc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   passes = 0;

  always #5 clk = ~clk;

  core_run_ctrl #(
    .RST_CYCLES(3),
    .MAX_CYCLES(20),
    .MIN_CYCLES(5),
    .END_INSTR (NOP)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .halt_req (halt_req),
    .step_req (step_req),
    .bp_en    (bp_en),
    .bp_addr  (bp_addr),
    .pc       (pc),
    .instr    (instr),
    .core_rst (core_rst),
    .core_en  (core_en),
    .state    (state),
    .cause    (cause),
    .cycle_cnt(cycle_cnt),
    .done     (done),
    .timeout  (timeout)
  );

  // Simple core: PC resets under core_rst, advances by 4 per retired
  // instruction through a 64-word program that wraps around.
  always @(posedge clk) begin
    if (core_rst) pc <= '0;
    else if (core_en) pc <= (pc + 32'd4) & 32'h0000_00FF;
  end
  assign instr = prog[pc[7:2]];

  task automatic check(input string name, input logic ok, input string detail);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s: %s", name, detail);
  endtask

  task automatic expect_stop(input string name, input logic [2:0] st, input logic [1:0] c,
                             input logic [31:0] cnt, input logic d, input logic to,
                             input logic [31:0] p);
    exp_t e;
    e.name = name; e.st = st; e.cause = c; e.cnt = cnt; e.done = d; e.to = to; e.pc = p;
    q.push_back(e);
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic pulse_step();
    @(negedge clk) step_req = 1'b1;
    @(negedge clk) step_req = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check({name, "_reached"}, q.size() == 0,
          $sformatf("pending=%0d expectations still queued, required 0", q.size()));
    q.delete();
  endtask

  // Monitor: every entry into HALT or DONE is a stop event checked against
  // the next queued expectation.
  initial begin : monitor
    logic [2:0] prev;
    exp_t e;
    prev = 3'd0;
    forever begin
      @(negedge clk);
      if (!reset && state != prev && (state == 3'd3 || state == 3'd5)) begin
        if (q.size() == 0) begin
          check("unexpected_stop", 1'b0,
                $sformatf("state=%0d cnt=%0d with no expectation queued", state, cycle_cnt));
        end else begin
          e = q.pop_front();
          check(e.name,
                state == e.st && cause == e.cause && cycle_cnt == e.cnt &&
                done == e.done && timeout == e.to && pc == e.pc,
                $sformatf("got st=%0d cause=%0d cnt=%0d done=%0d to=%0d pc=%h, want st=%0d cause=%0d cnt=%0d done=%0d to=%0d pc=%h",
                          state, cause, cycle_cnt, done, timeout, pc,
                          e.st, e.cause, e.cnt, e.done, e.to, e.pc));
        end
      end
      prev = state;
    end
  end

  initial begin : global_limit
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "time limit");
  end

  initial begin : stim
    int n;
    int rst_cyc;
    int bad;

    for (int i = 0; i < 64; i++) prog[i] = ADD;
    prog[8] = NOP;

    // Reset state
    @(negedge clk);
    check("reset_state",
          state == 3'd0 && core_rst == 1'b1 && core_en == 1'b0 && cycle_cnt == 32'd0 &&
          done == 1'b0 && timeout == 1'b0 && cause == 2'd0,
          $sformatf("got st=%0d rst=%0d en=%0d cnt=%0d done=%0d to=%0d cause=%0d, want 0/1/0/0/0/0/0",
                    state, core_rst, core_en, cycle_cnt, done, timeout, cause));
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // 8 instructions then NOP
    expect_stop("prog_done", 3'd5, 2'd0, 32'd9, 1'b1, 1'b0, 32'h24);
    pulse_start();
    rst_cyc = 0;
    n = 0;
    while (state == 3'd1 && n < 20) begin
      if (core_rst) rst_cyc++;
      @(negedge clk);
      n++;
    end
    check("rstc_cycles", rst_cyc == 3, $sformatf("got %0d core_rst cycles, want 3", rst_cyc));
    drain("prog_done");
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (core_en !== 1'b0 || state != 3'd5) bad++;
    end
    check("done_core_en_low", bad == 0, $sformatf("got %0d cycles with core_en high, want 0", bad));

    // Breakpoint at 0x10, then resume through it without re-halting
    bp_en = 1'b1;
    bp_addr = 32'h10;
    expect_stop("bp_halt", 3'd3, 2'd2, 32'd4, 1'b0, 1'b0, 32'h10);
    pulse_start();
    drain("bp_halt");
    expect_stop("bp_resume_done", 3'd5, 2'd2, 32'd9, 1'b1, 1'b0, 32'h24);
    pulse_start();
    drain("bp_resume_done");

    // Halt at breakpoint again, then two single steps
    expect_stop("bp_halt2", 3'd3, 2'd2, 32'd4, 1'b0, 1'b0, 32'h10);
    pulse_start();
    drain("bp_halt2");
    expect_stop("step1", 3'd3, 2'd3, 32'd5, 1'b0, 1'b0, 32'h14);
    pulse_step();
    drain("step1");
    expect_stop("step2", 3'd3, 2'd3, 32'd6, 1'b0, 1'b0, 32'h18);
    pulse_step();
    drain("step2");
    bp_en = 1'b0;
    expect_stop("step_resume_done", 3'd5, 2'd3, 32'd9, 1'b1, 1'b0, 32'h24);
    pulse_start();
    drain("step_resume_done");

    // halt_req and breakpoint in the same cycle: halt_req wins
    bp_en = 1'b1;
    bp_addr = 32'h0;
    halt_req = 1'b1;
    expect_stop("halt_over_bp", 3'd3, 2'd1, 32'd0, 1'b0, 1'b0, 32'h0);
    pulse_start();
    drain("halt_over_bp");
    halt_req = 1'b0;
    expect_stop("halt_resume_done", 3'd5, 2'd1, 32'd9, 1'b1, 1'b0, 32'h24);
    pulse_start();
    drain("halt_resume_done");
    bp_en = 1'b0;

    // End marker below MIN_CYCLES is ignored; at MIN_CYCLES it ends
    prog[4] = NOP;
    prog[5] = NOP;
    expect_stop("min_cycles_end", 3'd5, 2'd0, 32'd6, 1'b1, 1'b0, 32'h18);
    pulse_start();
    drain("min_cycles_end");
    prog[4] = ADD;
    prog[5] = ADD;
    prog[8] = ADD;

    // Watchdog on a program with no end marker
    expect_stop("watchdog", 3'd5, 2'd0, 32'd20, 1'b0, 1'b1, 32'h50);
    pulse_start();
    drain("watchdog");

    // Reset between clock edges while running
    pulse_start();
    n = 0;
    while (state != 3'd2 && n < 20) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("reset_mid_run",
          state == 3'd0 && core_rst == 1'b1 && core_en == 1'b0 && cycle_cnt == 32'd0 &&
          done == 1'b0 && timeout == 1'b0 && cause == 2'd0,
          $sformatf("got st=%0d rst=%0d en=%0d cnt=%0d done=%0d to=%0d cause=%0d, want 0/1/0/0/0/0/0",
                    state, core_rst, core_en, cycle_cnt, done, timeout, cause));
    @(negedge clk) reset = 1'b0;
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (state != 3'd0 || core_rst != 1'b1 || core_en != 1'b0) bad++;
    end
    check("idle_after_reset", bad == 0,
          $sformatf("got %0d cycles outside IDLE, want 0", bad));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule : tb_core_run_ctrl

// File: doc/core_run_ctrl.md
CORE_RUN_CTRL -- requirements
Module: core_run_ctrl

Interface
REQ-001 The block SHALL have parameter RST_CYCLES, default 3, the number of cycles core_rst is held after start.
REQ-002 The block SHALL have parameter MAX_CYCLES, default 1000, the watchdog limit in retired instructions.
REQ-003 The block SHALL have parameter MIN_CYCLES, default 5, the retired count below which end detection is ignored.
REQ-004 The block SHALL have parameter END_INSTR, default 32'h0000_0013, the end-of-program marker instruction.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 The block SHALL have port start, input, 1 bit: single-cycle pulse; restarts from IDLE/DONE, resumes from HALT.
REQ-008 The block SHALL have port halt_req, input, 1 bit: level; stops RUN before the current instruction retires.
REQ-009 The block SHALL have port step_req, input, 1 bit: single-cycle pulse; retires exactly one instruction from HALT.
REQ-010 The block SHALL have ports bp_en (input, 1 bit) and bp_addr (input, 32 bits): breakpoint enable and PC match address.
REQ-011 The block SHALL have ports pc (input, 32 bits) and instr (input, 32 bits): core PC and the instruction currently fetched.
REQ-012 The block SHALL have ports core_rst (output, 1 bit), core holding reset, and core_en (output, 1 bit), which lets the core retire the current instruction at the next edge.
REQ-013 The block SHALL have port state (output, 3 bits) giving the FSM encoding, and port cause (output, 2 bits): 0 none, 1 halt_req, 2 breakpoint, 3 step.
REQ-014 The block SHALL have port cycle_cnt (output, 32 bits): retired-instruction count since last start from IDLE/DONE.
REQ-015 The block SHALL have ports done (output, 1 bit), end of program reached, and timeout (output, 1 bit), watchdog expired.

Function
REQ-016 The FSM SHALL have states IDLE=0, RSTC=1, RUN=2, HALT=3, STEP=4, DONE=5.
REQ-017 core_rst SHALL be 1 in IDLE and RSTC and 0 in all other states.
REQ-018 IDLE, or DONE, plus start SHALL enter RSTC and clear cycle_cnt, done, timeout and cause.
REQ-019 RSTC SHALL last exactly RST_CYCLES cycles and then enter RUN.
REQ-020 core_en SHALL equal (state==RUN and not stop), or (state==STEP); it SHALL be combinational from state and inputs.
REQ-021 In RUN, stop SHALL be asserted, with priority first to last, for:
  - halt_req: enter HALT, cause=1.
  - bp_en and pc==bp_addr and skip flag clear: enter HALT, cause=2.
  - cycle_cnt==MAX_CYCLES: enter DONE, timeout=1.
REQ-022 In RUN, when instr==END_INSTR, cycle_cnt>=MIN_CYCLES and not stop, the instruction SHALL retire and the FSM SHALL enter DONE with done=1.
REQ-023 HALT plus start SHALL enter RUN and set the skip flag; HALT plus step_req, without start, SHALL enter STEP; start SHALL win if both are asserted.
REQ-024 STEP SHALL last exactly 1 cycle (core_en=1), then return to HALT with cause=3.
REQ-025 The skip flag SHALL clear after the first retiring cycle, so that resuming at a breakpoint PC executes that instruction once without re-halting.
REQ-026 cycle_cnt SHALL increment on every edge where core_en=1, saturate at 2^32-1, and never exceed MAX_CYCLES in RUN.
REQ-027 DONE SHALL hold core_rst=0 and core_en=0, preserving core state for inspection.
REQ-028 start, halt_req and step_req SHALL be ignored in states where they have no listed transition.

Reset
REQ-029 Asserting reset SHALL asynchronously force state=IDLE, core_rst=1, core_en=0, cycle_cnt=0, done=0, timeout=0, cause=0 and skip flag=0.
REQ-030 Reset mid-RUN or mid-RSTC SHALL abort immediately; after deassertion the block SHALL wait in IDLE for start.

Structure
REQ-031 Package riscv_ctrl_pkg SHALL hold the state enum, the cause enum and the NOP constant 32'h0000_0013.
REQ-032 The block SHALL instantiate one sub-module, sat_counter: 32-bit, with clear, enable and saturation; it is used for cycle_cnt.

Verification
REQ-033 The bench SHALL cover these scenarios:
  - start, program with 8 instructions then NOP: core_rst=1 for 3 cycles; done=1 with cycle_cnt=9; core_en=0 thereafter.
  - bp_en=1, bp_addr=0x10: HALT, cause=2, pc=0x10, cycle_cnt=4; start resumes with one retire at 0x10 and no re-halt.
  - from HALT, step_req x2: cycle_cnt +2, cause=3, state=HALT after each step.
  - MAX_CYCLES=20 on an infinite non-NOP loop: DONE at cycle_cnt=20, timeout=1, done=0.
  - halt_req and breakpoint in the same cycle: cause=1.
  - reset asserted during RUN, between clock edges: state=0, core_rst=1 and core_en=0 immediately.
